// File: rtl/loc_stack.sv
// loc_stack: a stack of locations that is built with push/pop and then
// read back bottom-first.
// Optional feature: define STACK_FULL_FLAG_EN to add the 'full' output port.
module loc_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] locIn,
  input  logic             push,
  input  logic             pop,
  input  logic             done,
  output logic [WIDTH-1:0] locOut,
  output logic             empStck
`ifdef STACK_FULL_FLAG_EN
  ,
  output logic             full
`endif
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE      = (AW+1)'(1);

  typedef enum logic {BUILD = 1'b0, READOUT = 1'b1} mode_t;

  mode_t            r_mode, w_mode_nxt;
  logic [AW:0]      r_sp, r_rp, w_sp_nxt, w_rp_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW:0]      w_sp_m1;
  logic             w_sp_empty, w_sp_full;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr, w_rd_addr;
  logic             w_rd_ok;

  assign w_sp_m1    = r_sp - ONE;
  assign w_sp_empty = (r_sp == '0);
  assign w_sp_full  = (r_sp == FULL_CNT);

  // Next-state: done wins over push/pop; build edits the top, readout walks rp upward.
  always_comb begin
    w_mode_nxt = r_mode;
    w_sp_nxt   = r_sp;
    w_rp_nxt   = r_rp;
    w_wr_en    = 1'b0;
    w_wr_addr  = r_sp[AW-1:0];
    if (done) begin
      w_mode_nxt = READOUT;
      w_rp_nxt   = '0;
    end else if (r_mode == BUILD) begin
      if (push && pop && !w_sp_empty) begin
        // replace the top entry in place
        w_wr_en   = 1'b1;
        w_wr_addr = w_sp_m1[AW-1:0];
      end else if (push && !w_sp_full) begin
        w_wr_en  = 1'b1;
        w_sp_nxt = r_sp + ONE;
      end else if (!push && pop && !w_sp_empty) begin
        w_sp_nxt = w_sp_m1;
      end
    end else if (pop && (r_rp != r_sp)) begin
      w_rp_nxt = r_rp + ONE;
    end
  end

  // Control state: pointers and mode, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= BUILD;
      r_sp   <= '0;
      r_rp   <= '0;
    end else begin
      r_mode <= w_mode_nxt;
      r_sp   <= w_sp_nxt;
      r_rp   <= w_rp_nxt;
    end
  end

  // Storage: never cleared; writes are held off while reset is asserted.
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) r_mem[w_wr_addr] <= locIn;
  end

  // Outputs depend on registered state only, never on the request inputs.
  always_comb begin
    w_rd_addr = (r_mode == BUILD) ? w_sp_m1[AW-1:0] : r_rp[AW-1:0];
    w_rd_ok   = (r_mode == BUILD) ? !w_sp_empty : (r_rp < r_sp);
    locOut    = w_rd_ok ? r_mem[w_rd_addr] : '0;
    empStck   = (r_mode == BUILD) ? w_sp_empty : (r_rp == r_sp);
  end

`ifdef STACK_FULL_FLAG_EN
  assign full = w_sp_full;
`endif

endmodule

// File: tb/tb_loc_stack.sv
// Self-checking bench for loc_stack: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_loc_stack;
  localparam int WIDTH = 8;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] locIn = '0;
  logic             push = 1'b0, pop = 1'b0, done = 1'b0;
  logic [WIDTH-1:0] locOut;
  logic             empStck;
`ifdef STACK_FULL_FLAG_EN
  logic             full;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model: stack contents as a queue (index 0 = first pushed), readout index.
  logic [WIDTH-1:0] q[$];
  bit               m_ro = 1'b0;
  int               m_rp = 0;

  always #5 clk = ~clk;

  loc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .locIn   (locIn),
    .push    (push),
    .pop     (pop),
    .done    (done),
    .locOut  (locOut),
    .empStck (empStck)
`ifdef STACK_FULL_FLAG_EN
    ,
    .full    (full)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] m_out();
    if (!m_ro) return (q.size() > 0) ? q[q.size()-1] : '0;
    return (m_rp < q.size()) ? q[m_rp] : '0;
  endfunction

  function automatic logic m_emp();
    if (!m_ro) return q.size() == 0;
    return m_rp == q.size();
  endfunction

  task automatic model_update(input bit p, input bit po, input bit d, input logic [WIDTH-1:0] v);
    if (d) begin
      m_ro = 1'b1;
      m_rp = 0;
    end else if (!m_ro) begin
      if (p && po && q.size() > 0) q[q.size()-1] = v;
      else if (p && q.size() < DEPTH) q.push_back(v);
      else if (!p && po && q.size() > 0) void'(q.pop_back());
    end else if (po && m_rp < q.size()) begin
      m_rp++;
    end
  endtask

  // One clock of requests; model advances just after the edge.
  task automatic step(input bit p, input bit po, input bit d, input logic [WIDTH-1:0] v);
    push = p; pop = po; done = d; locIn = v;
    @(posedge clk);
    #1;
    model_update(p, po, d, v);
    push = 1'b0; pop = 1'b0; done = 1'b0;
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset();
    #3 rst = 1'b1;
    q.delete();
    m_ro = 1'b0;
    m_rp = 0;
    #1;
    chk("rst_async_locOut", locOut, 0);
    chk("rst_async_empStck", empStck, 1);
`ifdef STACK_FULL_FLAG_EN
    chk("rst_async_full", full, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("model_locOut", locOut, m_out());
    chk("model_empStck", empStck, m_emp());
`ifdef STACK_FULL_FLAG_EN
    chk("model_full", full, (!rst && q.size() == DEPTH) ? 1 : 0);
`endif
  end

  initial begin
    bit p, po, d;
    async_reset();
    @(posedge clk); #1;
    chk("idle_locOut", locOut, 8'h00);
    chk("idle_empStck", empStck, 1);

    step(1, 0, 0, 8'h40);
    step(1, 0, 0, 8'h01);
    step(0, 1, 0, 8'h00);
    chk("pop_locOut", locOut, 8'h40);
    chk("pop_empStck", empStck, 0);

    step(1, 0, 0, 8'h40);
    step(1, 0, 0, 8'hA9);
    chk("top_A9", locOut, 8'hA9);
    step(0, 0, 1, 8'h00);
    chk("done_bottom", locOut, 8'h40);
    chk("done_empStck", empStck, 0);

    step(0, 1, 0, 8'h00); chk("ro_1", locOut, 8'h40);
    step(0, 1, 0, 8'h00); chk("ro_2", locOut, 8'hA9);
    step(0, 1, 0, 8'h00); chk("ro_end", locOut, 8'h00);
    chk("ro_end_emp", empStck, 1);
    step(0, 1, 0, 8'h00); chk("ro_extra_pop", locOut, 8'h00);
    step(1, 0, 0, 8'h55); chk("ro_push_ignored", locOut, 8'h00);
    chk("ro_push_emp", empStck, 1);

    async_reset();
    for (int i = 0; i <= DEPTH; i++) step(1, 0, 0, 8'(i));
    chk("overflow_top", locOut, 8'h3F);
`ifdef STACK_FULL_FLAG_EN
    chk("overflow_full", full, 1);
`endif
    step(1, 1, 0, 8'h77);
    chk("replace_top", locOut, 8'h77);
`ifdef STACK_FULL_FLAG_EN
    chk("replace_full", full, 1);
`endif

    step(0, 0, 1, 8'h00); chk("ro2_bottom", locOut, 8'h00);
    step(0, 1, 0, 8'h00); chk("ro2_1", locOut, 8'h01);
    step(0, 1, 0, 8'h00); chk("ro2_2", locOut, 8'h02);
    async_reset();
    step(1, 0, 0, 8'h12);
    chk("post_rst_push", locOut, 8'h12);
    chk("post_rst_emp", empStck, 0);

    // Randomized traffic: biased toward push so the stack grows and fills.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) < 4) begin
        async_reset();
      end else begin
        p  = ($urandom_range(0, 99) < 65);
        po = ($urandom_range(0, 99) < 35);
        d  = ($urandom_range(0, 99) < 1);
        step(p, po, d, 8'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
